uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Oversampling UART receive deframer for the raw RX pin. It synchronises the asynchronous serial input and recovers 8N1 frames using a programmable 16x sample tick and 2-of-3 majority voting. Each good byte is presented with a one-cycle strobe that drives the RX FIFO push directly. Frames with a bad stop bit are reported on a separate error strobe and are never pushed.

## Interface
- No parameters; the baud setting comes from a port and is normally wired to the UART frequency-divider register.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- rx_bit  in  1  raw serial input, asynchronous to clk; idle high.
- freq_divider  in  8  sample tick period = freq_divider+1 clk cycles (16 ticks per bit).
- data_out  out  8  last good byte, LSB received first; holds until the next good frame.
- data_valid  out  1  one-cycle pulse: data_out is new; connect to FIFO push.
- frame_err  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- busy  out  1  high whenever state != IDLE.

## Operation
- **Synchroniser:** two flops, both reset to 1. All logic uses the synchronised value rx_s only.
- **Tick generator:**
  - 8-bit div_cnt, reset 0.
  - When div_cnt >= freq_divider, tick=1 for one cycle and div_cnt<=0; otherwise div_cnt+1.
  - The >= compare makes a lowered freq_divider take effect with no 256-count wrap.
  - freq_divider=0 gives a tick every cycle.
- **Counters:** s_cnt (4-bit, ticks within a bit) and bit_idx (3-bit). Both advance only on tick.
- **Majority vote:** samples taken at s_cnt 7, 8 and 9. The voted bit is the majority of the three and is evaluated on the tick where s_cnt==9.
- **State machine** (all transitions occur on tick cycles only):
  - **IDLE:** if rx_s==0, go to START with s_cnt<=0.
  - **START:** s_cnt++.
    - At s_cnt==9, if the vote is 1, this is a false start: return to IDLE.
    - At s_cnt==15, go to DATA with s_cnt<=0, bit_idx<=0.
  - **DATA:** s_cnt++.
    - At s_cnt==9, shift the vote into shift[bit_idx].
    - At s_cnt==15, if bit_idx==7 go to STOP with s_cnt<=0; else bit_idx++.
  - **STOP:** s_cnt++.
    - At s_cnt==9, if the vote is 1: data_out<=shift, data_valid<=1, go to IDLE. The early exit at mid-stop allows resync to a back-to-back start bit.
    - At s_cnt==9, if the vote is 0: frame_err<=1, go to WAIT_HIGH.
  - **WAIT_HIGH:** if rx_s==1, go to IDLE. This prevents a break/low line from retriggering a frame.
- **Exclusivity:** data_valid and frame_err are never high in the same cycle.
- **freq_divider changes mid-frame:** apply from the next tick. Correctness of that frame is not required.

## Timing
- **Reset values:** data_out=0x00, data_valid=0, frame_err=0, busy=0, state=IDLE, synchroniser=1, div_cnt=0, s_cnt=0, bit_idx=0, shift=0.
- **Reset mid-frame:** the next cycle is IDLE with no strobe. A partial byte is lost and data_out is unchanged from its pre-reset value until reset clears it to 0.
- **Input latency:** 2 clk from rx_bit to rx_s.
- **Strobe timing:** data_valid and frame_err assert in the cycle after the STOP tick with s_cnt==9 (registered), for exactly 1 clk.
- **Frame duration:** from the first tick seeing rx_s low to data_valid is 16+8*16+10 ticks = 154 ticks, plus 1 clk.
- **busy:** registered; rises 1 clk after the IDLE->START tick and falls 1 clk after the return to IDLE.
- **Back-to-back frames:** a start bit beginning anywhere after the mid-stop point is accepted with no lost bytes.
- **FIFO full:** no backpressure. The consumer must accept a push every data_valid pulse.

## Test plan
- **Reset:** drive reset=0 for 3 clk with rx_bit toggling -> data_out=0x00, data_valid=0, frame_err=0, busy=0 throughout. Release -> still idle while rx_bit=1.
- **Single byte:** freq_divider=0, send 0x55 at 16 clk/bit with stop=1 -> exactly one data_valid pulse, data_out=0x55, frame_err never high. freq_divider=3 with 64 clk/bit, 0xC3 -> data_out=0xC3.
- **Back-to-back:** send 0xA5 then 0x3C with no idle gap (1 stop bit each) -> two data_valid pulses 160 ticks apart, values 0xA5 then 0x3C.
- **Noise rejection:**
  - A 3-tick low glitch on an idle line -> busy pulses, but no data_valid and no frame_err, and the block returns to IDLE.
  - A 1-tick inverted glitch at sample s_cnt==8 of bit 3 of 0x00 -> data_out=0x00 (majority corrects it).
- **Framing error:** send 0x81 with stop=0, then hold the line low for 40 bit times -> one frame_err pulse, no data_valid, data_out keeps its previous value, busy stays high until rx goes high. A following 0x7E frame is then received correctly.
- **Reset mid-frame:** assert reset during bit 4 of 0x99 -> idle within 1 clk and no strobe. A subsequent 0x42 frame -> data_out=0x42.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: two-flop synchroniser, 16x oversampling tick,
// 2-of-3 majority vote around mid-bit, good-byte and framing-error strobes.
module uart_rx_deframer (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic [7:0] freq_divider,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  logic [1:0] sync_q, sync_d;
  logic       rx_s;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic       tick;
  state_e     state_q, state_d;
  logic [3:0] s_cnt_q, s_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [1:0] samp_q, samp_d;
  logic       vote;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], rx_bit};
    // >= rather than == so a lowered divider never waits for an 8-bit wrap
    tick      = (div_cnt_q >= freq_divider);
    div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
    // samp_q holds the s_cnt==7 and s_cnt==8 samples; the third is live
    vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    bit_idx_d    = bit_idx_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (tick) begin
      if (state_q == START || state_q == DATA || state_q == STOP) begin
        s_cnt_d = s_cnt_q + 4'd1;
        if (s_cnt_q == 4'd7) samp_d[0] = rx_s;
        if (s_cnt_q == 4'd8) samp_d[1] = rx_s;
      end
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            s_cnt_d = 4'd0;
          end
        end
        START: begin
          if (s_cnt_q == 4'd9 && vote) begin
            state_d = IDLE;
          end else if (s_cnt_q == 4'd15) begin
            state_d   = DATA;
            s_cnt_d   = 4'd0;
            bit_idx_d = 3'd0;
          end
        end
        DATA: begin
          if (s_cnt_q == 4'd9) shift_d[bit_idx_q] = vote;
          if (s_cnt_q == 4'd15) begin
            s_cnt_d = 4'd0;
            if (bit_idx_q == 3'd7) state_d = STOP;
            else bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start bit is not missed
          if (s_cnt_q == 4'd9) begin
            if (vote) begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
              state_d      = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      div_cnt_q    <= 8'd0;
      state_q      <= IDLE;
      s_cnt_q      <= 4'd0;
      bit_idx_q    <= 3'd0;
      samp_q       <= 2'b00;
      shift_q      <= 8'd0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      bit_idx_q    <= bit_idx_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: stimulus pushes expected strobes into a
// queue, an independent negedge monitor pops and compares them.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_bit;
  logic [7:0] freq_divider;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic       exp_kind[$];
  logic [7:0] exp_data[$];
  int         dv_times[$];

  uart_rx_deframer dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .freq_divider (freq_divider),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    logic       k;
    logic [7:0] d;
    if (data_valid === 1'b1 || frame_err === 1'b1) begin
      checks++;
      if (exp_kind.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual dv=%0b fe=%0b data_out=%02h required none",
                 data_valid, frame_err, data_out);
      end else begin
        k = exp_kind.pop_front();
        d = exp_data.pop_front();
        if ((data_valid && frame_err) || (frame_err !== k) || (data_out !== d)) begin
          failures++;
          $display("FAIL strobe actual dv=%0b fe=%0b data_out=%02h required %s data_out=%02h",
                   data_valid, frame_err, data_out, k ? "frame_err" : "data_valid", d);
        end else begin
          $display("strobe %s data_out=%02h cycle=%0d", k ? "frame_err" : "data_valid", data_out, cyc);
        end
      end
      if (data_valid === 1'b1) dv_times.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic expect_strobe(input logic k, input logic [7:0] d);
    exp_kind.push_back(k);
    exp_data.push_back(d);
  endtask

  // Drives start, 8 data bits LSB first and stop; one entry per clk.
  // glitch_at inverts one clk; abort_at truncates the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb,
                            input int glitch_at, input int abort_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10 * cpb && i < abort_at; i++) begin
      rx_bit = fr[i / cpb] ^ (i == glitch_at);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_bit = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_kind.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_kind.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual pending=%0d required 0", name, exp_kind.size());
      exp_kind.delete();
      exp_data.delete();
    end
  endtask

  initial begin : stim
    logic saw_busy;
    int   t0;
    reset = 1'b0;
    rx_bit = 1'b1;
    freq_divider = 8'd0;

    // Reset with the line toggling
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_outputs", {data_out, data_valid, frame_err, busy}, 32'h0);
      rx_bit = ~rx_bit;
      @(negedge clk);
    end
    reset = 1'b1;
    idle(20);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_data", data_out, 8'h00);

    // Single byte, tick every clk
    expect_strobe(1'b0, 8'h55);
    send_frame(8'h55, 1'b1, 16, -1, 1 << 30);
    idle(20);
    wait_drain("byte_55", 200);

    // Single byte, divider 3
    freq_divider = 8'd3;
    idle(10);
    expect_strobe(1'b0, 8'hC3);
    send_frame(8'hC3, 1'b1, 64, -1, 1 << 30);
    idle(40);
    wait_drain("byte_c3", 800);
    freq_divider = 8'd0;
    idle(10);

    // Back-to-back frames
    dv_times.delete();
    expect_strobe(1'b0, 8'hA5);
    expect_strobe(1'b0, 8'h3C);
    send_frame(8'hA5, 1'b1, 16, -1, 1 << 30);
    send_frame(8'h3C, 1'b1, 16, -1, 1 << 30);
    idle(20);
    wait_drain("b2b", 400);
    check("b2b_count", dv_times.size(), 2);
    if (dv_times.size() == 2) check("b2b_spacing", dv_times[1] - dv_times[0], 160);

    // 3-tick low glitch on idle line
    saw_busy = 1'b0;
    rx_bit = 1'b0;
    repeat (3) @(negedge clk);
    rx_bit = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    check("glitch_busy_pulsed", saw_busy, 1'b1);
    check("glitch_back_idle", busy, 1'b0);

    // Glitch at s_cnt==8 of bit 3 of 0x00 is out-voted
    expect_strobe(1'b0, 8'h00);
    send_frame(8'h00, 1'b1, 16, 73, 1 << 30);
    idle(20);
    wait_drain("vote_00", 200);

    // Framing error, then long break
    expect_strobe(1'b1, 8'h00);
    send_frame(8'h81, 1'b0, 16, -1, 1 << 30);
    rx_bit = 1'b0;
    repeat (40 * 16) @(negedge clk);
    wait_drain("ferr", 10);
    check("ferr_busy_held", busy, 1'b1);
    idle(8);
    check("ferr_busy_released", busy, 1'b0);
    expect_strobe(1'b0, 8'h7E);
    send_frame(8'h7E, 1'b1, 16, -1, 1 << 30);
    idle(20);
    wait_drain("byte_7e", 200);
    check("data_before_reset", data_out, 8'h7E);

    // Reset in the middle of bit 4 of 0x99
    send_frame(8'h99, 1'b1, 16, -1, 16 * 5 + 8);
    check("midframe_busy_before", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("midframe_reset_busy", busy, 1'b0);
    check("midframe_reset_data", data_out, 8'h00);
    reset = 1'b1;
    idle(20);
    check("after_reset_idle", busy, 1'b0);
    t0 = dv_times.size();
    expect_strobe(1'b0, 8'h42);
    send_frame(8'h42, 1'b1, 16, -1, 1 << 30);
    idle(20);
    wait_drain("byte_42", 200);
    check("byte_42_single_pulse", dv_times.size() - t0, 1);

    idle(20);
    check("scoreboard_empty", exp_kind.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
